// File: rtl/pc_sequencer.sv
// pc_sequencer: XM23 fetch program counter with prioritised redirects and a one-entry
// pending slot that holds redirects across stalls. Define PC_RAS_EN to add a return-address stack.
module pc_sequencer #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}},
    parameter int              INC       = 2,
    parameter int              STALL_W   = 8,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STALL_W-1:0]         stall_in,
    input  logic                       branch_fail,
    input  logic [PC_W-1:0]            LBPC,
    input  logic                       link_back,
    input  logic [PC_W-1:0]            LR,
    input  logic                       irq_req,
    input  logic [PC_W-1:0]            irq_vec,
    input  logic                       call_push,
    input  logic [PC_W-1:0]            call_ret_addr,
    output logic [PC_W-1:0]            true_PC,
    output logic                       flush,
    output logic [1:0]                 redirect_src,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow
);
    localparam int         CW      = $clog2(RAS_DEPTH) + 1;
    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_BF  = 2'd1;
    localparam logic [1:0] SRC_LB  = 2'd2;
    localparam logic [1:0] SRC_IRQ = 2'd3;

    // The source code is not ordered by priority, so map it to a rank for comparisons.
    function automatic logic [1:0] rank(input logic [1:0] src);
        case (src)
            SRC_IRQ: rank = 2'd3;
            SRC_BF:  rank = 2'd2;
            SRC_LB:  rank = 2'd1;
            default: rank = 2'd0;
        endcase
    endfunction

    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic [1:0]      src_q, src_d;
    logic            pend_valid_q, pend_valid_d;
    logic [1:0]      pend_src_q, pend_src_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

    logic            stall_s, req_valid_s, take_req_s, pop_s;
    logic [1:0]      req_src_s, sel_src_s;
    logic [PC_W-1:0] req_tgt_s, sel_tgt_s, lb_tgt_s;

    assign stall_s = |stall_in;

    // Highest-priority request on the inputs this cycle.
    always_comb begin
        req_valid_s = 1'b1;
        req_src_s   = SRC_SEQ;
        req_tgt_s   = {PC_W{1'b0}};
        if (irq_req) begin
            req_src_s = SRC_IRQ;
            req_tgt_s = irq_vec;
        end else if (branch_fail) begin
            req_src_s = SRC_BF;
            req_tgt_s = LBPC;
        end else if (link_back) begin
            req_src_s = SRC_LB;
            req_tgt_s = lb_tgt_s;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    // Equal rank lets the newer (input) request replace the pending one.
    assign take_req_s = req_valid_s &&
                        (!pend_valid_q || (rank(req_src_s) >= rank(pend_src_q)));

    // Next PC, redirect source and pending-slot update.
    always_comb begin
        pc_d         = pc_q;
        flush_d      = 1'b0;
        src_d        = src_q;
        pend_valid_d = pend_valid_q;
        pend_src_d   = pend_src_q;
        pend_tgt_d   = pend_tgt_q;
        sel_src_s    = SRC_SEQ;
        sel_tgt_s    = {PC_W{1'b0}};
        pop_s        = 1'b0;
        if (stall_s) begin
            if (take_req_s) begin
                pend_valid_d = 1'b1;
                pend_src_d   = req_src_s;
                pend_tgt_d   = req_tgt_s;
            end else begin
                pend_valid_d = pend_valid_q;
            end
        end else if (take_req_s || pend_valid_q) begin
            sel_src_s    = take_req_s ? req_src_s : pend_src_q;
            sel_tgt_s    = take_req_s ? req_tgt_s : pend_tgt_q;
            pc_d         = sel_tgt_s;
            src_d        = sel_src_s;
            flush_d      = 1'b1;
            pend_valid_d = 1'b0;
            pop_s        = (sel_src_s == SRC_LB);
        end else begin
            pc_d         = pc_q + PC_W'(INC);
            src_d        = SRC_SEQ;
            pend_valid_d = 1'b0;
        end
    end

    // Architectural PC state and pending slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            flush_q      <= 1'b0;
            src_q        <= SRC_SEQ;
            pend_valid_q <= 1'b0;
            pend_src_q   <= SRC_SEQ;
            pend_tgt_q   <= {PC_W{1'b0}};
        end else begin
            pc_q         <= pc_d;
            flush_q      <= flush_d;
            src_q        <= src_d;
            pend_valid_q <= pend_valid_d;
            pend_src_q   <= pend_src_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    assign true_PC      = pc_q;
    assign flush        = flush_q;
    assign redirect_src = src_q;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [PC_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [PC_W-1:0] ras_mem_d [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            push_s, do_pop_s, ras_empty_s, ras_full_s;

    assign ras_empty_s = (cnt_q == {CW{1'b0}});
    assign ras_full_s  = (cnt_q == CW'(RAS_DEPTH));
    assign push_s      = call_push & ~stall_s;
    assign do_pop_s    = pop_s & ~ras_empty_s;
    assign lb_tgt_s    = ras_empty_s ? LR : ras_mem_q[top_q];

    // Circular stack: when full, a push advances over the oldest entry.
    always_comb begin
        ras_mem_d = ras_mem_q;
        top_d     = top_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        if (push_s && do_pop_s) begin
            ras_mem_d[top_q] = call_ret_addr;
        end else if (push_s) begin
            top_d            = top_q + PW'(1);
            ras_mem_d[top_d] = call_ret_addr;
            if (ras_full_s) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (do_pop_s) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Return-address stack state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= {PC_W{1'b0}};
            end
            top_q <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            ras_mem_q <= ras_mem_d;
            top_q     <= top_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ras_count    = cnt_q;
    assign ras_overflow = ovf_q;
`else
    logic unused_ras_s;

    assign lb_tgt_s     = LR;
    assign ras_count    = {CW{1'b0}};
    assign ras_overflow = 1'b0;
    assign unused_ras_s = ^{call_push, call_ret_addr, pop_s};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a queue-based
// reference model; RAS scenarios are exercised when PC_RAS_EN is defined.
module tb_pc_sequencer;
    localparam int RAS_DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  stall_in;
    logic        branch_fail, link_back, irq_req, call_push;
    logic [15:0] LBPC, LR, irq_vec, call_ret_addr;
    logic [15:0] true_PC;
    logic        flush;
    logic [1:0]  redirect_src;
    logic [2:0]  ras_count;
    logic        ras_overflow;

    pc_sequencer #(
        .PC_W(16), .RESET_VEC(16'h0000), .INC(2), .STALL_W(8), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .branch_fail(branch_fail), .LBPC(LBPC),
        .link_back(link_back), .LR(LR),
        .irq_req(irq_req), .irq_vec(irq_vec),
        .call_push(call_push), .call_ret_addr(call_ret_addr),
        .true_PC(true_PC), .flush(flush), .redirect_src(redirect_src),
        .ras_count(ras_count), .ras_overflow(ras_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_flush;
    logic [1:0]  m_src;
    logic        m_pv;
    logic [1:0]  m_psrc;
    logic [15:0] m_ptgt;
    logic [15:0] m_ras[$];
    logic        m_ovf;

    logic [15:0] held;
    logic [15:0] ret_exp [5];
    logic [7:0]  stall_pick;

    function automatic int prio(input logic [1:0] s);
        if (s == 2'd3) return 3;
        else if (s == 2'd1) return 2;
        else if (s == 2'd2) return 1;
        return 0;
    endfunction

    task automatic model_edge();
        logic        rv;
        logic [1:0]  rs;
        logic [15:0] rt;
        logic [15:0] lbt;
        if (rst) begin
            m_pc = 16'h0000; m_flush = 1'b0; m_src = 2'd0; m_pv = 1'b0;
            m_psrc = 2'd0; m_ptgt = 16'h0000; m_ras.delete(); m_ovf = 1'b0;
            return;
        end
        if (RAS_EN && m_ras.size() > 0) lbt = m_ras[$];
        else lbt = LR;
        rv = 1'b1; rs = 2'd0; rt = 16'h0000;
        if (irq_req) begin rs = 2'd3; rt = irq_vec; end
        else if (branch_fail) begin rs = 2'd1; rt = LBPC; end
        else if (link_back) begin rs = 2'd2; rt = lbt; end
        else rv = 1'b0;
        if (stall_in != 8'h00) begin
            m_flush = 1'b0;
            if (rv && (!m_pv || prio(rs) >= prio(m_psrc))) begin
                m_pv = 1'b1; m_psrc = rs; m_ptgt = rt;
            end
        end else begin
            if (m_pv && !(rv && prio(rs) >= prio(m_psrc))) begin
                rv = 1'b1; rs = m_psrc; rt = m_ptgt;
            end
            m_pv = 1'b0;
            if (rv) begin m_pc = rt; m_src = rs; m_flush = 1'b1; end
            else begin m_pc = m_pc + 16'd2; m_src = 2'd0; m_flush = 1'b0; end
            if (RAS_EN) begin
                if (rv && rs == 2'd2 && m_ras.size() > 0) void'(m_ras.pop_back());
                if (call_push) begin
                    if (m_ras.size() == RAS_DEPTH) begin
                        m_ras.delete(0);
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(call_ret_addr);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge with the inputs currently driven, then compare everything.
    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".pc"}, 32'(true_PC), 32'(m_pc));
        chk({tag, ".flush"}, 32'(flush), 32'(m_flush));
        chk({tag, ".src"}, 32'(redirect_src), 32'(m_src));
        chk({tag, ".ras_count"}, 32'(ras_count), 32'(m_ras.size()));
        chk({tag, ".ras_ovf"}, 32'(ras_overflow), 32'(m_ovf));
    endtask

    task automatic idle();
        stall_in = 8'h00; branch_fail = 1'b0; link_back = 1'b0;
        irq_req = 1'b0; call_push = 1'b0;
    endtask

    initial begin
        idle();
        LBPC = 16'h0000; LR = 16'h0000; irq_vec = 16'h0000; call_ret_addr = 16'h0000;
        ret_exp = '{16'h0050, 16'h0040, 16'h0030, 16'h0020, 16'h0600};

        // reset, then sequential fetch
        rst = 1'b1;
        cyc("rst0");
        cyc("rst1");
        chk("reset_pc", 32'(true_PC), 32'h0000);
        chk("reset_flush", 32'(flush), 32'h0);
        rst = 1'b0;
        cyc("seq1");
        chk("seq_pc2", 32'(true_PC), 32'h0002);
        cyc("seq2");
        chk("seq_pc4", 32'(true_PC), 32'h0004);

        // wrap at the top of the address space
        branch_fail = 1'b1; LBPC = 16'hFFFE;
        cyc("to_fffe");
        chk("bf_pc", 32'(true_PC), 32'hFFFE);
        chk("bf_src", 32'(redirect_src), 32'd1);
        branch_fail = 1'b0;
        cyc("wrap");
        chk("wrap_pc", 32'(true_PC), 32'h0000);
        chk("wrap_src", 32'(redirect_src), 32'd0);

        // irq beats branch_fail in the same cycle
        branch_fail = 1'b1; LBPC = 16'h0100; irq_req = 1'b1; irq_vec = 16'h0040;
        cyc("irq_bf");
        chk("irq_pc", 32'(true_PC), 32'h0040);
        chk("irq_src", 32'(redirect_src), 32'd3);
        chk("irq_flush", 32'(flush), 32'h1);
        idle();
        cyc("irq_after");
        chk("irq_flush_drop", 32'(flush), 32'h0);
        chk("irq_next_pc", 32'(true_PC), 32'h0042);

        // stalled redirects: later, higher-priority branch_fail replaces link_back
        held = m_pc;
        stall_in = 8'h01; link_back = 1'b1; LR = 16'h0200;
        cyc("stall1");
        chk("stall1_hold", 32'(true_PC), 32'(held));
        link_back = 1'b0; branch_fail = 1'b1; LBPC = 16'h0300;
        cyc("stall2");
        chk("stall2_hold", 32'(true_PC), 32'(held));
        branch_fail = 1'b0;
        cyc("stall3");
        chk("stall3_hold", 32'(true_PC), 32'(held));
        stall_in = 8'h00;
        cyc("unstall");
        chk("unstall_pc", 32'(true_PC), 32'h0300);
        chk("unstall_src", 32'(redirect_src), 32'd1);

        // reset while a branch_fail is pending
        stall_in = 8'h80; branch_fail = 1'b1; LBPC = 16'h0500;
        cyc("pend_bf");
        branch_fail = 1'b0; rst = 1'b1;
        cyc("pend_rst");
        chk("pend_rst_pc", 32'(true_PC), 32'h0000);
        rst = 1'b0; stall_in = 8'h00;
        cyc("pend_gone");
        chk("pend_gone_pc", 32'(true_PC), 32'h0002);
        chk("pend_gone_src", 32'(redirect_src), 32'd0);

`ifdef PC_RAS_EN
        // five pushes into a four-entry stack, then five returns
        call_push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            call_ret_addr = 16'(i * 16);
            cyc("push");
        end
        call_push = 1'b0;
        chk("ras_ovf", 32'(ras_overflow), 32'h1);
        chk("ras_full", 32'(ras_count), 32'd4);
        link_back = 1'b1; LR = 16'h0600;
        for (int i = 0; i < 5; i++) begin
            cyc("ret");
            chk("ret_pc", 32'(true_PC), 32'(ret_exp[i]));
        end
        idle();
`endif

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst         = ($urandom_range(0, 63) == 0);
            stall_pick  = 8'h01 << $urandom_range(0, 7);
            stall_in    = ($urandom_range(0, 2) == 0) ? stall_pick : 8'h00;
            irq_req     = ($urandom_range(0, 7) == 0);
            branch_fail = ($urandom_range(0, 5) == 0);
            link_back   = ($urandom_range(0, 4) == 0);
            call_push   = ($urandom_range(0, 2) == 0);
            LBPC          = 16'($urandom);
            LR            = 16'($urandom);
            irq_vec       = 16'($urandom);
            call_ret_addr = 16'($urandom);
            cyc("rand");
        end

        idle();
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised fetch program-counter sequencer for the XM23 pipeline; replaces the fixed 16-bit PC register.
- Holds the architectural fetch PC and advances it sequentially by an internal increment.
- Applies prioritised redirects: interrupt, branch-fail restore, link-back return.
- Remembers redirects that arrive while the pipeline is stalled, and optionally predicts return targets with a small return-address stack (RAS).

Parameters:
- PC_W, 16: PC width in bits.
- RESET_VEC, 16'h0000: PC value after reset, PC_W bits.
- INC, 2: sequential increment, bytes per instruction.
- STALL_W, 8: number of stall request lines.
- RAS_DEPTH, 4: RAS entries, power of two ≥2. Used only with PC_RAS_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_in  in  STALL_W  any bit set = stall; PC holds.
- branch_fail  in  1  mispredict; redirect to LBPC.
- LBPC  in  PC_W  branch-fail restore target.
- link_back  in  1  return; redirect to RAS top or LR.
- LR  in  PC_W  link register; return target when the RAS is absent or empty.
- irq_req  in  1  interrupt entry request.
- irq_vec  in  PC_W  interrupt vector target.
- call_push  in  1  call retired; push call_ret_addr onto the RAS.
- call_ret_addr  in  PC_W  return address to push.
- true_PC  out  PC_W  current fetch PC.
- flush  out  1  one-cycle pulse, aligned with the first cycle of a redirected true_PC.
- redirect_src  out  2  source of the last PC update: 0 sequential, 1 branch_fail, 2 link_back, 3 irq.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.

Behaviour:
Reset:
- rst high at an edge sets true_PC=RESET_VEC, flush=0, redirect_src=0, pending cleared, ras_count=0, ras_overflow=0.
- rst overrides all other inputs, including mid-stall and mid-pending.

Redirect priority and pending slot:
- Priority order: irq > branch_fail > link_back.
- Single pending slot holds {valid, src, target}.
- Each edge while stalled (|stall_in=1, rst=0): true_PC holds, flush=0.
  - The highest-priority asserted request is compared with the pending slot.
  - If the request's priority is ≥ the pending priority, or the slot is empty, it overwrites the slot and its target is captured.
  - Equal priority: the newest request wins.
- Each edge while not stalled:
  - Candidate = best of (pending, current inputs); on equal priority the current input wins.
  - Candidate present: true_PC <= target, redirect_src <= src, flush <= 1, pending cleared.
  - No candidate: true_PC <= true_PC+INC, truncated modulo 2^PC_W (wraps, no flag); redirect_src <= 0, flush <= 0.
- Latency: a redirect applies one edge after the first unstalled cycle; with no stall it appears on true_PC the cycle after assertion.
- A link_back target is resolved when the request is captured (pending slot or direct apply), not when it is applied.
- A redirect that loses priority in the same cycle is discarded; it is not queued.

RAS (PC_RAS_EN only):
- Push and pop take effect only on unstalled edges.
- Push: call_push=1 writes call_ret_addr to the top.
  - If full: the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, ras_overflow <= 1.
- Pop: occurs when a link_back redirect is applied.
  - Non-empty: target = top, ras_count-1.
  - Empty: target = LR, count stays 0.
- Push and pop in the same edge: the pop target is the top before the edge; the new address replaces the top; ras_count is unchanged. If the RAS was empty, the target is LR and the push then gives ras_count=1.
- A link_back that is captured into the pending slot but not yet applied does not pop. The target recorded in the slot is the current RAS top, or LR if the RAS is empty.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: RAS instantiated as above; link_back targets the RAS top when non-empty.
- Undefined:
  - No RAS storage.
  - link_back always targets LR.
  - call_push and call_ret_addr are ignored.
  - ras_count and ras_overflow are tied to 0.

Test Plan:
- rst=1 then released, no requests, PC_W=16, INC=2 -> true_PC 0x0000, 0x0002, 0x0004 on successive cycles; flush=0.
- true_PC=0xFFFE, no requests -> next cycle true_PC=0x0000, redirect_src=0.
- branch_fail=1 with LBPC=0x0100 and irq_req=1 with irq_vec=0x0040, same cycle -> true_PC=0x0040, redirect_src=3, flush pulses for one cycle; branch_fail is dropped.
- stall_in=8'h01 for 3 cycles; link_back (LR=0x0200) in cycle 1, branch_fail (LBPC=0x0300) in cycle 2 -> PC held throughout; first unstalled edge gives true_PC=0x0300, redirect_src=1.
- PC_RAS_EN, RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_overflow=1, ras_count=4; five link_backs -> targets 0x50, 0x40, 0x30, 0x20, then LR.
- rst asserted while stalled with a branch_fail pending -> after release true_PC=RESET_VEC and the pending redirect is never applied.
